eth_phy_10g_rx_dec: RTL and testbench

Receive-side 64b/66b block decoder for the 10GBASE-R PHY. It consumes the descrambled, header-tagged blocks from the PHY RX interface stage and produces a 64-bit XGMII data/control word each cycle. It also generates the `rx_bad_block` and `rx_sequence_error` pulses that the RX watchdog consumes.

---
 rtl/eth_phy_10g_pkg.sv | 71 +++++++
 rtl/eth_phy_10g_rx_dec.sv | 171 +++++++++++++++++
 tb/tb_eth_phy_10g_rx_dec.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10GBASE-R constants: sync headers, block types, XGMII characters and
// the 7-bit control-code to XGMII character mapping.
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BT_IDLE    = 8'h1E;
    localparam logic [7:0] BT_S0      = 8'h78;
    localparam logic [7:0] BT_S4      = 8'h33;
    localparam logic [7:0] BT_OS0     = 8'h4B;
    localparam logic [7:0] BT_OS0_S4  = 8'h66;
    localparam logic [7:0] BT_OS0_OS4 = 8'h55;
    localparam logic [7:0] BT_OS4     = 8'h2D;
    localparam logic [7:0] BT_T0      = 8'h87;
    localparam logic [7:0] BT_T1      = 8'h99;
    localparam logic [7:0] BT_T2      = 8'hAA;
    localparam logic [7:0] BT_T3      = 8'hB4;
    localparam logic [7:0] BT_T4      = 8'hCC;
    localparam logic [7:0] BT_T5      = 8'hD2;
    localparam logic [7:0] BT_T6      = 8'hE1;
    localparam logic [7:0] BT_T7      = 8'hFF;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] ch;
    } xgmii_char_t;

    function automatic xgmii_char_t map_ctrl_code(input logic [6:0] code);
        xgmii_char_t r;
        r.valid = 1'b1;
        r.ch    = XGMII_ERROR;
        case (code)
            CC_IDLE:  r.ch = XGMII_IDLE;
            CC_ERROR: r.ch = XGMII_ERROR;
            default:  r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Lane index of /T/ for a terminate block type.
    function automatic logic [2:0] term_lane(input logic [7:0] bt);
        logic [2:0] k;
        case (bt)
            BT_T1:   k = 3'd1;
            BT_T2:   k = 3'd2;
            BT_T3:   k = 3'd3;
            BT_T4:   k = 3'd4;
            BT_T5:   k = 3'd5;
            BT_T6:   k = 3'd6;
            BT_T7:   k = 3'd7;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_dec.sv
// 10GBASE-R 64b/66b receive block decoder: one block per cycle into a
// registered XGMII word, with bad-block and framing-order error pulses.
//
// state    | meaning
// ST_IDLE  | between frames; expecting a start block
// ST_FRAME | inside a frame; expecting data or terminate
module eth_phy_10g_rx_dec
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    input  logic                  rx_block_lock,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic                  rx_bad_block,
    output logic                  rx_sequence_error
);

    frame_state_e state_q, state_d;
    logic [63:0]  rxd_q, rxd_d;
    logic [7:0]   rxc_q, rxc_d;
    logic         bad_q, bad_d;
    logic         seq_q, seq_d;

    logic [63:0]  dec_rxd;
    logic [7:0]   dec_rxc;
    logic [63:0]  data_sh;
    logic [2:0]   term_k;
    logic         blk_bad, is_data, is_start, is_term;
    xgmii_char_t  ch;

    always_comb begin
        dec_rxd  = {8{XGMII_IDLE}};
        dec_rxc  = 8'hFF;
        data_sh  = encoded_rx_data >> 8;
        term_k   = term_lane(encoded_rx_data[7:0]);
        blk_bad  = 1'b0;
        is_data  = 1'b0;
        is_start = 1'b0;
        is_term  = 1'b0;
        ch       = '0;
        case (encoded_rx_hdr)
            SYNC_DATA: begin
                dec_rxd = encoded_rx_data;
                dec_rxc = 8'h00;
                is_data = 1'b1;
            end
            SYNC_CTRL: begin
                case (encoded_rx_data[7:0])
                    BT_IDLE: begin
                        for (int j = 0; j < 8; j++) begin
                            ch = map_ctrl_code(encoded_rx_data[8+7*j +: 7]);
                            dec_rxd[8*j +: 8] = ch.ch;
                            if (!ch.valid) blk_bad = 1'b1;
                        end
                    end
                    BT_S0: begin
                        dec_rxd  = {encoded_rx_data[63:8], XGMII_START};
                        dec_rxc  = 8'h01;
                        is_start = 1'b1;
                    end
                    BT_S4: begin
                        dec_rxd  = {encoded_rx_data[63:40], XGMII_START, {4{XGMII_IDLE}}};
                        dec_rxc  = 8'h1F;
                        is_start = 1'b1;
                    end
                    BT_OS0: begin
                        dec_rxd = {{4{XGMII_IDLE}}, encoded_rx_data[31:8], XGMII_SEQ};
                        dec_rxc = 8'hF1;
                    end
                    BT_OS0_S4: begin
                        dec_rxd  = {encoded_rx_data[63:40], XGMII_START,
                                    encoded_rx_data[31:8], XGMII_SEQ};
                        dec_rxc  = 8'h11;
                        is_start = 1'b1;
                    end
                    BT_OS0_OS4: begin
                        dec_rxd = {encoded_rx_data[63:40], XGMII_SEQ,
                                   encoded_rx_data[31:8], XGMII_SEQ};
                        dec_rxc = 8'h11;
                    end
                    BT_OS4: begin
                        dec_rxd = {encoded_rx_data[63:40], XGMII_SEQ, {4{XGMII_IDLE}}};
                        dec_rxc = 8'h1F;
                    end
                    BT_T0, BT_T1, BT_T2, BT_T3, BT_T4, BT_T5, BT_T6, BT_T7: begin
                        is_term = 1'b1;
                        // Lanes past /T/ are forced idle; their coded bits are don't-care.
                        for (int j = 0; j < 8; j++) begin
                            if (j < int'(term_k)) begin
                                dec_rxd[8*j +: 8] = data_sh[8*j +: 8];
                                dec_rxc[j]        = 1'b0;
                            end else if (j == int'(term_k)) begin
                                dec_rxd[8*j +: 8] = XGMII_TERM;
                            end
                        end
                    end
                    default: blk_bad = 1'b1;
                endcase
            end
            default: blk_bad = 1'b1;
        endcase
        if (blk_bad) begin
            dec_rxd = {8{XGMII_ERROR}};
            dec_rxc = 8'hFF;
        end
    end

    always_comb begin
        state_d = state_q;
        rxd_d   = dec_rxd;
        rxc_d   = dec_rxc;
        bad_d   = 1'b0;
        seq_d   = 1'b0;
        if (!rx_block_lock) begin
            state_d = ST_IDLE;
            rxd_d   = {8{XGMII_IDLE}};
            rxc_d   = 8'hFF;
        end else if (blk_bad) begin
            // A bad block masks any sequence violation it would also cause.
            bad_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_start) state_d = ST_FRAME;
                    else if (is_data || is_term) seq_d = 1'b1;
                end
                ST_FRAME: begin
                    if (is_term) begin
                        state_d = ST_IDLE;
                    end else if (is_start) begin
                        seq_d = 1'b1;
                    end else if (!is_data) begin
                        seq_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rxd_q   <= {8{XGMII_IDLE}};
            rxc_q   <= 8'hFF;
            bad_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rxd_q   <= rxd_d;
            rxc_q   <= rxc_d;
            bad_q   <= bad_d;
            seq_q   <= seq_d;
        end
    end

    assign xgmii_rxd         = rxd_q;
    assign xgmii_rxc         = rxc_q;
    assign rx_bad_block      = bad_q;
    assign rx_sequence_error = seq_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_dec.sv
// Bench for the 64b/66b RX decoder: directed scenarios with literal expected
// words, then random blocks against a lane-level reference model.
module tb_eth_phy_10g_rx_dec;

    logic        clk;
    logic        rst_n;
    logic [63:0] encoded_rx_data;
    logic [1:0]  encoded_rx_hdr;
    logic        rx_block_lock;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_bad_block;
    logic        rx_sequence_error;

    int n_cmp = 0;
    int n_err = 0;
    bit m_frame;

    localparam logic [7:0] TERM_TYPES [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] DATA_W = 64'h0123456789ABCDEF;
    localparam logic [63:0] S0_IN  = 64'h0123456789ABCD78;
    localparam logic [63:0] S0_OUT = 64'h0123456789ABCDFB;

    eth_phy_10g_rx_dec #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .HDR_WIDTH(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .encoded_rx_data   (encoded_rx_data),
        .encoded_rx_hdr    (encoded_rx_hdr),
        .rx_block_lock     (rx_block_lock),
        .xgmii_rxd         (xgmii_rxd),
        .xgmii_rxc         (xgmii_rxc),
        .rx_bad_block      (rx_bad_block),
        .rx_sequence_error (rx_sequence_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [1:0] hdr, input logic [63:0] d, input bit lock,
                        output logic [73:0] obs);
        encoded_rx_hdr  = hdr;
        encoded_rx_data = d;
        rx_block_lock   = lock;
        @(posedge clk);
        #1;
        obs = {xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error};
    endtask

    // Reference: build the eight output lanes from the block rules, then apply
    // lock, bad-block and framing-order rules.
    function automatic void ref_decode(input logic [1:0] hdr, input logic [63:0] d,
                                       input bit lock, input bit in_frame,
                                       output logic [73:0] exp_o, output bit frame_o);
        logic [7:0]  lane [8];
        bit          ctl [8];
        logic [7:0]  bt;
        logic [6:0]  code;
        logic [63:0] rxd;
        logic [7:0]  rxc;
        bit          bad, seq;
        int          kind;   // 0 data, 1 start, 2 terminate, 3 other control
        int          k;
        bt = d[7:0]; bad = 0; seq = 0; kind = 3; k = -1;
        for (int i = 0; i < 8; i++) begin lane[i] = 8'h07; ctl[i] = 1; end
        for (int i = 0; i < 8; i++) if (TERM_TYPES[i] == bt) k = i;
        if (hdr == 2'b10) begin
            for (int i = 0; i < 8; i++) begin lane[i] = d[8*i +: 8]; ctl[i] = 0; end
            kind = 0;
        end else if (hdr != 2'b01) begin
            bad = 1;
        end else if (bt == 8'h1E) begin
            for (int i = 0; i < 8; i++) begin
                code = 7'((d >> (8 + 7*i)) & 64'h7F);
                if (code == 7'h00) lane[i] = 8'h07;
                else if (code == 7'h1E) lane[i] = 8'hFE;
                else bad = 1;
            end
        end else if (bt == 8'h78) begin
            lane[0] = 8'hFB;
            for (int i = 1; i < 8; i++) begin lane[i] = d[8*i +: 8]; ctl[i] = 0; end
            kind = 1;
        end else if (bt == 8'h33 || bt == 8'h66 || bt == 8'h55 || bt == 8'h2D) begin
            lane[4] = (bt == 8'h33 || bt == 8'h66) ? 8'hFB : 8'h9C;
            for (int i = 5; i < 8; i++) begin lane[i] = d[8*i +: 8]; ctl[i] = 0; end
            if (bt == 8'h66 || bt == 8'h55) begin
                lane[0] = 8'h9C;
                for (int i = 1; i < 4; i++) begin lane[i] = d[8*i +: 8]; ctl[i] = 0; end
            end
            if (bt == 8'h33 || bt == 8'h66) kind = 1;
        end else if (bt == 8'h4B) begin
            lane[0] = 8'h9C;
            for (int i = 1; i < 4; i++) begin lane[i] = d[8*i +: 8]; ctl[i] = 0; end
        end else if (k >= 0) begin
            for (int j = 0; j < k; j++) begin lane[j] = d[8*j+8 +: 8]; ctl[j] = 0; end
            lane[k] = 8'hFD;
            kind = 2;
        end else begin
            bad = 1;
        end
        frame_o = in_frame;
        if (!lock) begin
            for (int i = 0; i < 8; i++) begin lane[i] = 8'h07; ctl[i] = 1; end
            bad = 0;
            frame_o = 0;
        end else if (bad) begin
            for (int i = 0; i < 8; i++) begin lane[i] = 8'hFE; ctl[i] = 1; end
            frame_o = 0;
        end else if (!in_frame) begin
            if (kind == 1) frame_o = 1;
            else if (kind == 0 || kind == 2) seq = 1;
        end else begin
            if (kind == 2) frame_o = 0;
            else if (kind == 1) seq = 1;
            else if (kind == 3) begin seq = 1; frame_o = 0; end
        end
        for (int i = 0; i < 8; i++) begin rxd[8*i +: 8] = lane[i]; rxc[i] = ctl[i]; end
        exp_o = {rxd, rxc, bad, seq};
    endfunction

    task automatic gen_block(output logic [1:0] hdr, output logic [63:0] d);
        int sel;
        logic [63:0] codes;
        d   = {$urandom, $urandom};
        hdr = 2'b01;
        sel = $urandom_range(0, 15);
        if (sel <= 4) begin
            hdr = 2'b10;
        end else if (sel == 5 || sel == 6) begin
            codes = 64'h0;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 1) == 1) codes = codes | (64'h1E << (8 + 7*i));
            if (sel == 6) codes = codes | (64'h2A << (8 + 7*$urandom_range(0, 7)));
            d = codes | 64'h1E;
        end else if (sel == 7)  d[7:0] = 8'h78;
        else if (sel == 8)  d[7:0] = 8'h33;
        else if (sel == 9)  d[7:0] = 8'h4B;
        else if (sel == 10) d[7:0] = 8'h66;
        else if (sel == 11) d[7:0] = 8'h55;
        else if (sel == 12) d[7:0] = 8'h2D;
        else if (sel <= 14) d[7:0] = TERM_TYPES[$urandom_range(0, 7)];
        else if ($urandom_range(0, 1) == 1) hdr = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        else d[7:0] = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'hF0;
    endtask

    task automatic test_reset();
        encoded_rx_hdr  = 2'b10;
        encoded_rx_data = DATA_W;
        rx_block_lock   = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error} !== {IDLE_W, 8'hFF, 2'b00}) begin
            n_err++;
            $display("FAIL reset got %h/%h/%b/%b want %h/ff/0/0", xgmii_rxd, xgmii_rxc,
                     rx_bad_block, rx_sequence_error, IDLE_W);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal_frame();
        logic [1:0]  th [4];
        logic [63:0] td [4];
        logic [73:0] te [4];
        logic [73:0] obs;
        th = '{2'b01, 2'b10, 2'b10, 2'b01};
        td = '{S0_IN, DATA_W, DATA_W, 64'h0000000000005A99};
        te = '{{S0_OUT, 8'h01, 2'b00}, {DATA_W, 8'h00, 2'b00}, {DATA_W, 8'h00, 2'b00},
               {64'h070707070707FD5A, 8'hFE, 2'b00}};
        for (int i = 0; i < 4; i++) begin
            step(th[i], td[i], 1'b1, obs);
            n_cmp++;
            if (obs !== te[i]) begin
                n_err++;
                $display("FAIL normal[%0d] got %h want %h", i, obs, te[i]);
            end
        end
    endtask

    task automatic test_bad_inputs();
        logic [1:0]  th [3];
        logic [63:0] td [3];
        logic [73:0] obs;
        th = '{2'b11, 2'b01, 2'b01};
        td = '{DATA_W, 64'h0123456789ABCD12, 64'h0000000000002A1E};
        for (int i = 0; i < 3; i++) begin
            step(th[i], td[i], 1'b1, obs);
            n_cmp++;
            if (obs !== {ERR_W, 8'hFF, 2'b10}) begin
                n_err++;
                $display("FAIL bad[%0d] got %h want %h", i, obs, {ERR_W, 8'hFF, 2'b10});
            end
        end
    endtask

    task automatic test_sequence_errors();
        logic [1:0]  th [9];
        logic [63:0] td [9];
        logic [73:0] te [9];
        logic [73:0] obs;
        th = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        td = '{DATA_W, S0_IN, S0_IN, DATA_W, 64'h1E, DATA_W, S0_IN, 64'h0123456789ABCD12, DATA_W};
        te = '{{DATA_W, 8'h00, 2'b01}, {S0_OUT, 8'h01, 2'b00}, {S0_OUT, 8'h01, 2'b01},
               {DATA_W, 8'h00, 2'b00}, {IDLE_W, 8'hFF, 2'b01}, {DATA_W, 8'h00, 2'b01},
               {S0_OUT, 8'h01, 2'b00}, {ERR_W, 8'hFF, 2'b10}, {DATA_W, 8'h00, 2'b01}};
        for (int i = 0; i < 9; i++) begin
            step(th[i], td[i], 1'b1, obs);
            n_cmp++;
            if (obs !== te[i]) begin
                n_err++;
                $display("FAIL seq[%0d] got %h want %h", i, obs, te[i]);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [1:0]  th [5];
        logic [63:0] td [5];
        bit          tl [5];
        logic [73:0] te [5];
        logic [73:0] obs;
        th = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
        td = '{S0_IN, DATA_W, DATA_W, DATA_W, DATA_W};
        tl = '{1, 1, 0, 0, 1};
        te = '{{S0_OUT, 8'h01, 2'b00}, {DATA_W, 8'h00, 2'b00}, {IDLE_W, 8'hFF, 2'b00},
               {IDLE_W, 8'hFF, 2'b00}, {DATA_W, 8'h00, 2'b01}};
        for (int i = 0; i < 5; i++) begin
            step(th[i], td[i], tl[i], obs);
            n_cmp++;
            if (obs !== te[i]) begin
                n_err++;
                $display("FAIL lock[%0d] got %h want %h", i, obs, te[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [73:0] obs;
        step(2'b01, S0_IN, 1'b1, obs);
        step(2'b10, DATA_W, 1'b1, obs);
        #2;
        rst_n = 1'b0;
        #1;
        obs = {xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error};
        n_cmp++;
        if (obs !== {IDLE_W, 8'hFF, 2'b00}) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs, {IDLE_W, 8'hFF, 2'b00});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b10, DATA_W, 1'b1, obs);
        n_cmp++;
        if (obs !== {DATA_W, 8'h00, 2'b01}) begin
            n_err++;
            $display("FAIL post_reset_data got %h want %h", obs, {DATA_W, 8'h00, 2'b01});
        end
    endtask

    task automatic test_random();
        logic [1:0]  hdr;
        logic [63:0] d;
        bit          lock;
        bit          nxt;
        logic [73:0] exp_o, obs;
        m_frame = 1'b0;
        for (int n = 0; n < 400; n++) begin
            gen_block(hdr, d);
            lock = ($urandom_range(0, 15) != 0);
            ref_decode(hdr, d, lock, m_frame, exp_o, nxt);
            step(hdr, d, lock, obs);
            m_frame = nxt;
            n_cmp++;
            if (obs !== exp_o) begin
                n_err++;
                $display("FAIL random[%0d] hdr=%b d=%h lock=%0d got %h want %h",
                         n, hdr, d, lock, obs, exp_o);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        rx_block_lock   = 1'b0;
        encoded_rx_hdr  = 2'b00;
        encoded_rx_data = 64'h0;
        test_reset();
        test_normal_frame();
        test_bad_inputs();
        test_sequence_errors();
        test_lock_loss();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
